// File: rtl/cpu_pkg.sv
// Shared definitions for the unified program/data memory and its users.
//   - Memory geometry: DATA_W-bit words, ADDR_W-bit addresses, MEM_DEPTH words.
//   - arb_state_t: memory arbiter FSM encoding (INIT clear sweep, RUN).
//   - opcode_t: CPU opcodes, kept here for code that interprets memory contents.
package cpu_pkg;

   localparam int DATA_W    = 12;
   localparam int ADDR_W    = 6;
   localparam int MEM_DEPTH = 64;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } arb_state_t;

   typedef enum logic [2:0] {
      LOAD  = 3'd0,
      STORE = 3'd1,
      ADD   = 3'd2,
      SUB   = 3'd3,
      MUL   = 3'd4,
      DIV   = 3'd5
   } opcode_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with ownership lock.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   req[1:0]     : per-port requests
//   lock[1:0]    : per-port lock, only meaningful on that port's granted cycle
//   enable       : arbitration allowed (low forces no grant)
//   gnt[1:0]     : combinational one-hot (or zero) grant
// The pointer names the port that wins a tie; it flips to the other port
// after every grant. A granted port with lock=1 becomes owner and wins
// whenever it requests; ownership ends when the owner is granted with lock=0.
module rr_arb2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] lock,
   input  logic       enable,
   output logic [1:0] gnt
);

   logic ptr;        // tie-break winner: 0 = port 0, 1 = port 1
   logic owner_vld;
   logic owner;
   logic win;        // index of the granted port (valid when |gnt)

   always_comb begin
      gnt = 2'b00;
      if (enable) begin
         if (owner_vld && req[owner]) begin
            gnt[owner] = 1'b1;
         end else if (req == 2'b11) begin
            gnt[ptr] = 1'b1;
         end else begin
            // At most one request here (an idle owner lets the other through).
            gnt = req;
         end
      end
   end

   assign win = gnt[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr       <= 1'b0;
         owner_vld <= 1'b0;
         owner     <= 1'b0;
      end else if (|gnt) begin
         ptr <= ~win;
         if (lock[win]) begin
            owner_vld <= 1'b1;
            owner     <= win;
         end else if (owner_vld && (owner == win)) begin
            owner_vld <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Unified 64x12 program/data memory with a single port shared by two
// requesters (port 0: CPU, port 1: loader/debug).
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   reqN/weN/lockN     : request, write enable, ownership lock for port N
//   addrN/wdataN       : access address and write data for port N
//   gntN               : access for port N happens at this posedge
//   rvalidN/rdataN     : one-cycle read-valid pulse / read data (held)
//   busy               : high while the post-reset clear sweep runs
// After reset the memory is swept to zero (one word per cycle) before any
// grant is issued; pending requests simply wait. The FSM state is visible
// on busy (busy == INIT).
module mem_port_arbiter #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic              lock0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy
);
   import cpu_pkg::*;

   arb_state_t        state, state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [1:0]        gnt_vec;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   rr_arb2 u_arb (
      .clock  (clock),
      .reset  (reset),
      .req    ({req1, req0}),
      .lock   ({lock1, lock0}),
      .enable (state == ST_RUN),
      .gnt    (gnt_vec)
   );

   assign gnt0 = gnt_vec[0];
   assign gnt1 = gnt_vec[1];
   assign busy = (state == ST_INIT);

   // FSM: state register
   always_ff @(posedge clock) begin
      if (reset) state <= ST_INIT;
      else       state <= state_nxt;
   end

   // FSM: next state. RUN is only left through reset.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_INIT;
      endcase
   end

   // Clear-sweep address; wraps back to 0 as INIT ends, unused in RUN.
   always_ff @(posedge clock) begin
      if (reset)                 cnt <= '0;
      else if (state == ST_INIT) cnt <= cnt + 1'b1;
   end

   // Single memory write port: clear sweep or the granted writer.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      if (state == ST_INIT) begin
         wr_en   = 1'b1;
         wr_addr = cnt;
      end else if (gnt0 && we0) begin
         wr_en   = 1'b1;
         wr_addr = addr0;
         wr_data = wdata0;
      end else if (gnt1 && we1) begin
         wr_en   = 1'b1;
         wr_addr = addr1;
         wr_data = wdata1;
      end
   end

   // A grant that coincides with reset is dropped; the sweep rewrites anyway.
   always_ff @(posedge clock) begin
      if (wr_en && !reset) mem[wr_addr] <= wr_data;
   end

   // Read registers: data sampled at the grant edge, rdata held between reads.
   always_ff @(posedge clock) begin
      if (reset) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= gnt0 && !we0;
         rvalid1 <= gnt1 && !we1;
         if (gnt0 && !we0) rdata0 <= mem[addr0];
         if (gnt1 && !we1) rdata1 <= mem[addr1];
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Owns the 64-word x 12-bit unified program/data memory.
- Shares its single port between two requesters:
  - port 0: CPU fetch/operand path
  - port 1: program loader / debug port
- Arbitration is round-robin, with an optional lock for multi-access sequences.
- After reset, clears the whole memory before granting any access.

Parameters:
- DATA_W, 12, memory word width
- ADDR_W, 6, address width
- DEPTH, 64, number of words (must equal 2**ADDR_W)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 access request; held until granted
- we0  in  1  port 0 write enable (1=write, 0=read)
- lock0  in  1  port 0 keeps ownership while high (sampled on granted cycles)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- gnt0  out  1  port 0 access performed at this posedge
- rvalid0  out  1  port 0 read data valid
- rdata0  out  DATA_W  port 0 read data
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- busy  out  1  high while the init clear sequence runs

Behaviour:
- Clock/reset: single clock. Reset is synchronous and active-high; reset is sampled only on the rising edge of clock.
- Reset values: gnt0/1=0, rvalid0/1=0, rdata0/1=0, busy=1, FSM=INIT, init counter=0, priority pointer=port 0, lock owner=none.
- FSM states:
  - INIT: each cycle writes 0 to memory[cnt] and increments cnt. When cnt==DEPTH-1 and that write completes, go to RUN and drop busy. INIT lasts exactly DEPTH cycles; busy is low from cycle DEPTH+1 after reset release.
    - No grants in INIT; requests are ignored but stay pending.
  - RUN: arbitration and accesses. RUN is left only by reset.
- Arbitration in RUN (gnt is combinational from req/pointer/owner):
  - At most one of gnt0/gnt1 is high in any cycle.
  - Only one request high: grant it.
  - Both requests high, no owner: grant the pointer's port.
  - After every grant, the pointer moves to the other port.
  - Owner set: the owner is granted whenever its req is high.
    - If the owner's req is low, the other port may be granted.
    - Ownership is kept until the owner's lock is seen low on a granted cycle.
- Lock rules:
  - Owner is set when the granted port has lock=1.
  - Owner is cleared when the owner is granted with lock=0.
  - Lock is ignored on cycles where that port is not granted.
- Access timing:
  - The access happens at the posedge where gnt is high.
  - Write: mem[addr] <= wdata.
  - Read: rdata<port> <= mem[addr] and rvalid<port> <= 1 at that same posedge, i.e. data is visible the cycle after gnt.
  - rvalid is a one-cycle pulse per read.
  - rdata holds its last value until the next read on that port.
  - Writes never pulse rvalid.
- Throughput: back-to-back grants are allowed, one access per cycle total.
- Read-after-write: a write at cycle N followed by a read of the same address at N+1 returns the new data.
- Reset mid-operation: any in-flight rvalid is squashed, the owner and pointer are cleared, and INIT restarts at address 0.
- Requester contract:
  - Keep req/we/addr/wdata stable until gnt.
  - Deassert req, or present the next request, in the cycle after gnt.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W=12, ADDR_W=6, MEM_DEPTH=64
  - FSM state encoding INIT/RUN
  - CPU opcode constants LOAD=0, STORE=1, ADD=2, SUB=3, MUL=4, DIV=5, kept alongside for users of the memory contents
- One sub-module, rr_arb2:
  - Inputs: clock, reset, req[1:0], lock[1:0], enable.
  - Outputs: gnt[1:0].
  - Contains the pointer and owner registers.
- Memory array, INIT counter and read registers stay in mem_port_arbiter.

Test Plan:
- Init clear: release reset, hold req0=1 reading addr 5.
  - busy=1 for 64 cycles, no gnt during that time.
  - gnt0 on the first RUN cycle; next cycle rvalid0=1, rdata0=12'h000.
- Basic write/read: port 1 writes 12'h415 to addr 11, then reads addr 11 on the next cycle.
  - gnt1 on both cycles; rvalid1=1 with rdata1=12'h415 one cycle after the read grant.
- Round-robin: req0 and req1 held continuously, reading addr 20 (=12'h006) and addr 21 (=12'h004).
  - Grants alternate 0,1,0,1 starting with port 0.
  - rdata0=12'h006 and rdata1=12'h004 on alternating cycles.
- Lock: port 1 holds lock1=1 with req1 for 3 accesses while req0 is also high.
  - gnt1 for 3 consecutive cycles.
  - The 4th access has lock1=0 and is still granted to port 1; gnt0 is granted the following cycle.
- Reset mid-operation: assert reset for 1 cycle while a port 0 read is granted.
  - rvalid0 stays 0, busy=1, and INIT restarts at address 0.
  - Previously written addr 11 reads back 12'h000 after INIT completes.
- Idle: no requests in RUN.
  - gnt0/1=0 and rvalid0/1=0; rdata holds its last value; pointer unchanged.
